hist_accum_ctrl: RTL and testbench
==================================

# hist_accum_ctrl

Sequencer for the 256×17 dual-port histogram SRAM (port 0 write-only, port 1 read-only, 1-cycle read latency). Per frame, it:
- clears every bin to zero;
- accumulates one pixel bin per cycle by read-modify-write, with write-to-read forwarding;
- streams the finished histogram out over a valid/ready interface.

It sits between the pixel pipeline and the SRAM macro and is the macro's only master.

## Interface
- DATA_WIDTH, 17, bin count width (matches SRAM word)
- ADDR_WIDTH, 8, bin index width; 2^ADDR_WIDTH bins

Ports:
- clk_i  in  1  clock; the only clock
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a frame; ignored while busy_o=1
- pix_valid_i  in  1  pixel bin valid
- pix_ready_o  out  1  pixel accepted when valid&ready
- pix_bin_i  in  ADDR_WIDTH  bin index of pixel
- pix_last_i  in  1  marks final pixel of frame (qualified by handshake)
- hist_valid_o  out  1  histogram word valid
- hist_ready_i  in  1  consumer ready
- hist_bin_o  out  ADDR_WIDTH  bin index of word
- hist_count_o  out  DATA_WIDTH  bin count
- hist_last_o  out  1  high with bin 255
- busy_o  out  1  high in any state but IDLE
- done_o  out  1  one-cycle pulse after bin 255 handshake
- sram_csb0_o  out  1  write chip select, active-low
- sram_addr0_o  out  ADDR_WIDTH  write address
- sram_din0_o  out  DATA_WIDTH  write data
- sram_csb1_o  out  1  read chip select, active-low
- sram_addr1_o  out  ADDR_WIDTH  read address
- sram_dout1_i  in  DATA_WIDTH  read data, valid the cycle after the read is issued

## Operation
- States and transitions:
  - IDLE → CLEAR on start_i.
  - CLEAR → ACCUM after 256 zero writes, addr 0..255, one per cycle.
  - ACCUM → DRAIN on accepting a pixel with pix_last_i.
  - DRAIN → READOUT once pipeline stages S1 and W are empty (2 cycles).
  - READOUT → IDLE after bin 255 handshake; done_o pulses that cycle+1.
- pix_ready_o = 1 only in ACCUM. The pipeline never stalls in ACCUM.
- Accept cycle: drive csb1=0, addr1=bin; load S1 with {valid, bin}.
- S1 cycle:
  - Selection: old = (W.valid && W.bin==S1.bin) ? W.value : sram_dout1_i.
  - Update: new = (old == 2^DATA_WIDTH−1) ? old : old+1 (saturating).
  - Write: drive csb0=0, addr0=S1.bin, din0=new; load W with {valid, bin, new}.
- W covers the write/read collision on the same SRAM negedge. Writes 2+ cycles old are already committed.
- READOUT:
  - Reads bins 0..255 in order into a 2-entry output FIFO.
  - A read is issued only if (fifo entries + read in flight − pop this cycle) < 2.
  - With hist_ready_i held high, throughput is 1 word/cycle.
- Readout does not modify SRAM. Counts persist until the next CLEAR.
- SRAM chip selects are high in every cycle with no access. The same address is never read and written in the same cycle, except the forwarded case.

## Timing
- Reset values:
  - Control: state IDLE; S1, W and FIFO invalid.
  - pix_ready_o=0, hist_valid_o=0, hist_last_o=0, busy_o=0, done_o=0.
  - hist_bin_o=0, hist_count_o=0.
  - sram_csb0_o=1, sram_csb1_o=1, sram addr/din=0.
- CLEAR takes exactly 256 cycles; pix_ready_o rises the cycle after the last zero write.
- Pixel accept to SRAM write strobe: 1 cycle. Accept to count visible in SRAM: 2 cycles.
- First hist_valid_o: 2 cycles after entering READOUT.
- hist_* outputs hold stable while valid && !ready.
- Reset mid-operation: immediate return to IDLE with reset values; SRAM contents are undefined and the next start re-clears.
- start_i during busy: ignored, no queueing.
- Saturation at 131071 is sticky per bin; no overflow flag.

## Structure
- Package hist_pkg holds:
  - state enum {IDLE, CLEAR, ACCUM, DRAIN, READOUT};
  - HIST_BINS=256;
  - HIST_MAX = 2^DATA_WIDTH−1.
- Sub-module hist_out_fifo: 2-entry valid/ready FIFO carrying {bin, count, last}.
- The remainder is a single controller with a bin counter, S1/W pipeline registers and a read-in-flight flag.

## Test plan
- start, no pixels except a single pix_last on bin 0 → readout of 256 words: bin 0 = 1, all others 0, hist_last_o on bin 255, done_o one pulse.
- Back-to-back pixels on bin 7 ×4 (last on 4th) → bin 7 = 4; forwarding path exercised on pixels 2–4.
- Pixel sequence 3,3,4,3,4,4,200 (last) → bin 3 = 3, bin 4 = 3, bin 200 = 1.
- 131073 pixels on bin 9 → bin 9 = 131071 (saturated), neighbours 0.
- Readout with hist_ready_i toggling 1,0,0,1 repeating → all 256 words in order, none lost or duplicated, outputs stable while stalled.
- rstn_i low mid-ACCUM, then a new start and 5 pixels on bin 1 → bin 1 = 5, prior partial counts gone; csb0/csb1 high during reset.

Source files
------------

// File: rtl/hist_pkg.sv
// hist_pkg: shared constants and state encoding
// for the histogram SRAM sequencer.
package hist_pkg;

  localparam int HIST_DW   = 17;
  localparam int HIST_AW   = 8;
  localparam int HIST_BINS = 1 << HIST_AW;
  localparam int HIST_MAX  = (1 << HIST_DW) - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    READOUT
  } state_e;

endpackage

// File: rtl/hist_accum_ctrl_if.sv
// hist_accum_ctrl_if: pixel-in and histogram-out
// valid/ready streams of the histogram sequencer.
interface hist_accum_ctrl_if
  import hist_pkg::*;
#(
  parameter int ADDR_WIDTH = HIST_AW,
  parameter int DATA_WIDTH = HIST_DW
);

  logic                  pix_valid_i;
  logic                  pix_ready_o;
  logic [ADDR_WIDTH-1:0] pix_bin_i;
  logic                  pix_last_i;

  logic                  hist_valid_o;
  logic                  hist_ready_i;
  logic [ADDR_WIDTH-1:0] hist_bin_o;
  logic [DATA_WIDTH-1:0] hist_count_o;
  logic                  hist_last_o;

  modport master (
    output pix_valid_i, pix_bin_i, pix_last_i,
    output hist_ready_i,
    input  pix_ready_o,
    input  hist_valid_o, hist_bin_o,
    input  hist_count_o, hist_last_o
  );

  modport slave (
    input  pix_valid_i, pix_bin_i, pix_last_i,
    input  hist_ready_i,
    output pix_ready_o,
    output hist_valid_o, hist_bin_o,
    output hist_count_o, hist_last_o
  );

endinterface

// File: rtl/hist_out_fifo.sv
// hist_out_fifo: 2-entry valid/ready FIFO that
// decouples SRAM read latency from the consumer.
module hist_out_fifo #(
  parameter int WIDTH = 26
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && valid_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/hist_accum_ctrl.sv
// hist_accum_ctrl: clears, accumulates and reads out
// a 256-bin histogram held in a 1R1W SRAM macro.
module hist_accum_ctrl
  import hist_pkg::*;
#(
  parameter int DATA_WIDTH = HIST_DW,
  parameter int ADDR_WIDTH = HIST_AW
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  hist_accum_ctrl_if.slave      bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sram_csb0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  output logic                  sram_csb1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr1_o,
  input  logic [DATA_WIDTH-1:0] sram_dout1_i
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] BIN_LAST = '1;
  localparam int FW = ADDR_WIDTH + DATA_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_all_q, rd_all_d;
  logic                  s1_v_q;
  logic [ADDR_WIDTH-1:0] s1_bin_q;
  logic                  w_v_q;
  logic [ADDR_WIDTH-1:0] w_bin_q;
  logic [DATA_WIDTH-1:0] w_val_q;
  logic                  rd_v_q;
  logic [ADDR_WIDTH-1:0] rd_bin_q;
  logic                  done_q;

  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  fin;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] new_val;
  logic [1:0]            fifo_cnt;
  logic                  fifo_valid;
  logic [FW-1:0]         fifo_head;
  logic [ADDR_WIDTH-1:0] head_bin;
  logic [DATA_WIDTH-1:0] head_cnt;
  logic                  head_last;

  assign accept  = (state_q == ACCUM) && bus.pix_valid_i;
  // W holds the write that lands on the same edge as this read
  assign old_val = (w_v_q && (w_bin_q == s1_bin_q))
                 ? w_val_q : sram_dout1_i;
  assign new_val = (old_val == CNT_MAX)
                 ? old_val : old_val + DATA_WIDTH'(1);

  assign pop   = fifo_valid && bus.hist_ready_i;
  assign issue = (state_q == READOUT) && !rd_all_q
              && (({1'b0, fifo_cnt} + {2'b00, rd_v_q}
                  - {2'b00, pop}) < 3'd2);
  assign fin   = (state_q == READOUT) && pop && head_last;

  assign {head_bin, head_cnt, head_last} = fifo_head;

  assign bus.pix_ready_o  = (state_q == ACCUM);
  assign bus.hist_valid_o = fifo_valid;
  assign bus.hist_bin_o   = head_bin;
  assign bus.hist_count_o = head_cnt;
  assign bus.hist_last_o  = fifo_valid && head_last;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_all_d     = rd_all_q;
    sram_csb0_o  = 1'b1;
    sram_addr0_o = '0;
    sram_din0_o  = '0;
    sram_csb1_o  = 1'b1;
    sram_addr1_o = '0;
    if (s1_v_q) begin
      sram_csb0_o  = 1'b0;
      sram_addr0_o = s1_bin_q;
      sram_din0_o  = new_val;
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        sram_csb0_o  = 1'b0;
        sram_addr0_o = cnt_q;
        sram_din0_o  = '0;
        cnt_d        = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == BIN_LAST) state_d = ACCUM;
      end
      ACCUM: begin
        if (accept) begin
          sram_csb1_o  = 1'b0;
          sram_addr1_o = bus.pix_bin_i;
          if (bus.pix_last_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // W empties on the same edge S1 is seen empty
        if (!s1_v_q) begin
          state_d  = READOUT;
          cnt_d    = '0;
          rd_all_d = 1'b0;
        end
      end
      READOUT: begin
        if (issue) begin
          sram_csb1_o  = 1'b0;
          sram_addr1_o = cnt_q;
          cnt_d        = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == BIN_LAST) rd_all_d = 1'b1;
        end
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_all_q <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_bin_q <= '0;
      w_v_q    <= 1'b0;
      w_bin_q  <= '0;
      w_val_q  <= '0;
      rd_v_q   <= 1'b0;
      rd_bin_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_all_q <= rd_all_d;
      s1_v_q   <= accept;
      s1_bin_q <= bus.pix_bin_i;
      w_v_q    <= s1_v_q;
      w_bin_q  <= s1_bin_q;
      w_val_q  <= new_val;
      rd_v_q   <= issue;
      if (issue) rd_bin_q <= cnt_q;
      done_q   <= fin;
    end
  end

  hist_out_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (rd_v_q),
    .data_i  ({rd_bin_q, sram_dout1_i, rd_bin_q == BIN_LAST}),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_hist_accum_ctrl.sv
// tb_hist_accum_ctrl: directed frames against a
// behavioural 1R1W SRAM with hand-computed histograms.
module tb_hist_accum_ctrl;

  localparam int AW = 8;
  localparam int DW = 17;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          csb0, csb1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout = '0;

  hist_accum_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hist_accum_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .sram_csb0_o  (csb0),
    .sram_addr0_o (addr0),
    .sram_din0_o  (din0),
    .sram_csb1_o  (csb1),
    .sram_addr1_o (addr1),
    .sram_dout1_i (dout)
  );

  always #5 clk = ~clk;

  // read sees pre-write contents when both hit one address in a cycle
  logic [DW-1:0] mem [256];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_val = '0;

  always @(posedge clk) begin
    if (!csb1) dout <= mem[addr1];
    if (pre_en) mem[pre_addr] <= pre_val;
    if (!csb0) mem[addr0] <= din0;
  end

  int exp_cnt [256];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_cnt[i] = 0;
  endtask

  task automatic start_frame();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_first", {csb0, addr0, din0}, {1'b0, 8'd0, 17'd0});
    n = 1;
    while (!bus.pix_ready_o && n < 400) begin
      tick();
      n++;
    end
    chk("clear_len", n, 257);
  endtask

  task automatic pix(input logic [AW-1:0] b, input logic l);
    bus.pix_valid_i = 1'b1;
    bus.pix_bin_i   = b;
    bus.pix_last_i  = l;
    tick();
  endtask

  task automatic pix_end();
    bus.pix_valid_i = 1'b0;
    bus.pix_last_i  = 1'b0;
    bus.pix_bin_i   = '0;
  endtask

  task automatic readout(input int mode);
    int            got, t_rd0, t_v0, t_last;
    logic          rdy, stalled;
    logic [25:0]   saved, obs, expw;
    logic [AW-1:0] eb;
    logic [DW-1:0] ec;
    got = 0; t_rd0 = -1; t_v0 = -1; t_last = -1;
    stalled = 1'b0; saved = '0;
    for (int cyc = 0; cyc < 3000 && got < 256; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      bus.hist_ready_i = rdy;
      if (t_rd0 < 0 && !csb1 && addr1 == 0) t_rd0 = cyc;
      if (bus.hist_valid_o) begin
        if (t_v0 < 0) t_v0 = cyc;
        obs = {bus.hist_bin_o, bus.hist_count_o, bus.hist_last_o};
        if (stalled) chk("hold", obs, saved);
        if (rdy) begin
          eb = got[AW-1:0];
          ec = exp_cnt[got][DW-1:0];
          expw = {eb, ec, got == 255};
          chk("word", obs, expw);
          if (got == 255) t_last = cyc;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          saved = obs;
        end
      end
      tick();
    end
    bus.hist_ready_i = 1'b0;
    chk("word_total", got, 256);
    chk("first_valid", t_v0 - t_rd0, 2);
    if (mode == 0) chk("throughput", t_last - t_v0, 255);
    chk("done_pulse", {done, busy}, {1'b1, 1'b0});
    tick();
    chk("done_clear", done, 1'b0);
  endtask

  initial begin
    bus.pix_valid_i  = 1'b0;
    bus.pix_bin_i    = '0;
    bus.pix_last_i   = 1'b0;
    bus.hist_ready_i = 1'b0;
    #12;
    chk("rst_pix_ready", bus.pix_ready_o, 1'b0);
    chk("rst_hist", {bus.hist_valid_o, bus.hist_last_o,
        bus.hist_bin_o, bus.hist_count_o}, '0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_sram", {csb0, csb1, addr0, din0, addr1},
        {2'b11, 33'd0});
    #3 rstn = 1'b1;
    tick();

    // single last pixel on bin 0
    clear_exp();
    start_frame();
    pix(0, 1'b1);
    pix_end();
    exp_cnt[0] = 1;
    readout(0);

    // back-to-back hits on one bin need forwarding
    clear_exp();
    start_frame();
    pix(7, 1'b0);
    chk("wr_strobe", {csb0, addr0, din0}, {1'b0, 8'd7, 17'd1});
    pix(7, 1'b0);
    chk("fwd_2", din0, 17'd2);
    pix(7, 1'b0);
    chk("fwd_3", din0, 17'd3);
    pix(7, 1'b1);
    chk("fwd_4", din0, 17'd4);
    pix_end();
    exp_cnt[7] = 4;
    readout(0);

    // mixed bins, stalled consumer, start while busy
    clear_exp();
    start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", {busy, bus.pix_ready_o}, 2'b11);
    pix(3, 1'b0); pix(3, 1'b0); pix(4, 1'b0); pix(3, 1'b0);
    pix(4, 1'b0); pix(4, 1'b0); pix(200, 1'b1);
    pix_end();
    exp_cnt[3] = 3; exp_cnt[4] = 3; exp_cnt[200] = 1;
    readout(1);
    tick(); tick();
    chk("no_queue", busy, 1'b0);

    // saturation: preload bin 9 near the top
    clear_exp();
    start_frame();
    pre_addr = 9; pre_val = 17'd131069; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
    pix(9, 1'b0);
    chk("sat_1", din0, 17'd131070);
    pix(9, 1'b0);
    chk("sat_2", din0, 17'd131071);
    pix(9, 1'b0);
    chk("sat_3", din0, 17'd131071);
    pix(9, 1'b1);
    chk("sat_4", din0, 17'd131071);
    pix_end();
    exp_cnt[9] = 131071;
    readout(0);

    // reset mid-accumulate, then a fresh frame
    start_frame();
    pix(1, 1'b0); pix(1, 1'b0); pix(1, 1'b0); pix(2, 1'b0);
    pix_end();
    #2 rstn = 1'b0;
    #1;
    chk("midrst_sram", {csb0, csb1}, 2'b11);
    chk("midrst_ctl", {busy, done, bus.pix_ready_o,
        bus.hist_valid_o}, 4'b0000);
    tick(); tick();
    rstn = 1'b1;
    tick();
    clear_exp();
    start_frame();
    pix(1, 1'b0); pix(1, 1'b0); pix(1, 1'b0); pix(1, 1'b0);
    pix(1, 1'b1);
    pix_end();
    exp_cnt[1] = 5;
    readout(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
